// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and defaults for the I2C bus arbiter
package i2c_pkg;

    // Arbiter FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } arbState;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_TIMEOUT_MAX = 4095;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker, first set req at or after ptr
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    localparam int SW = IW + 1;

    logic [SW-1:0] slot;

    // Scan from the farthest slot back to ptr so the nearest set request wins last
    always_comb begin
        grant = '0;
        index = '0;
        slot  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            slot = {1'b0, ptr} + SW'(i);
            if (slot >= SW'(N)) begin
                slot = slot - SW'(N);
            end
            if (req[slot[IW-1:0]]) begin
                grant                = '0;
                grant[slot[IW-1:0]]  = 1'b1;
                index                = slot[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - round-robin sharing of one I2C write engine between requesters
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_MAX = DEFAULT_TIMEOUT_MAX
) (
    input  logic                          clock,
    input  logic                          Reset,
    input  logic [NUM_REQ-1:0]            Request,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] RequestData,
    output logic [NUM_REQ-1:0]            Grant,
    output logic [NUM_REQ-1:0]            Done,
    output logic                          AckError,
    output logic                          Go,
    output logic [DATA_WIDTH-1:0]         WriteData,
    input  logic                          Busy,
    input  logic                          AckBit
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_MAX + 1);
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_MAX);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);

    arbState              state;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        grantedIdx;
    logic [IW-1:0]        pickIdx;
    logic [NUM_REQ-1:0]   pickGrant;
    logic                 busyPrev;
    logic                 busyRise;

    // Only a fresh 0->1 on Busy counts as the engine accepting Go
    assign busyRise = Busy & ~busyPrev;

    rr_picker #(
        .N(NUM_REQ)
    ) picker (
        .req   (Request),
        .ptr   (ptr),
        .grant (pickGrant),
        .index (pickIdx)
    );

    // Busy history for edge detection
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            busyPrev <= 1'b0;
        end else begin
            busyPrev <= Busy;
        end
    end

    // Arbitration / handshake FSM with timer, data latch and round-robin pointer
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            Grant      <= '0;
            Done       <= '0;
            AckError   <= 1'b0;
            Go         <= 1'b0;
            WriteData  <= '0;
            ptr        <= '0;
            grantedIdx <= '0;
            timer      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|Request) begin
                        state <= ARB;
                        timer <= '0;
                    end
                end

                ARB: begin
                    timer <= '0;
                    // Requests are level signals; if they vanished meanwhile, nobody wins
                    if (|Request) begin
                        Grant      <= pickGrant;
                        grantedIdx <= pickIdx;
                        WriteData  <= RequestData[int'(pickIdx)*DATA_WIDTH +: DATA_WIDTH];
                        Go         <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end

                ISSUE: begin
                    if (busyRise) begin
                        Go    <= 1'b0;
                        timer <= '0;
                        state <= WAIT;
                    end else if (timer == TIMER_LIMIT) begin
                        Go       <= 1'b0;
                        timer    <= '0;
                        Done     <= Grant;
                        AckError <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT: begin
                    if (!Busy) begin
                        timer    <= '0;
                        Done     <= Grant;
                        AckError <= AckBit;
                        state    <= DONE;
                    end else if (timer == TIMER_LIMIT) begin
                        timer    <= '0;
                        Done     <= Grant;
                        AckError <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                DONE: begin
                    Done     <= '0;
                    AckError <= 1'b0;
                    Grant    <= '0;
                    timer    <= '0;
                    ptr      <= (grantedIdx == LAST_IDX) ? '0 : grantedIdx + 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    Go       <= 1'b0;
                    Grant    <= '0;
                    Done     <= '0;
                    AckError <= 1'b0;
                    timer    <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb/tb_i2c_bus_arbiter.sv - directed self-checking bench for i2c_bus_arbiter
module tb_i2c_bus_arbiter;

    localparam int TMAX = 4095;

    logic        clock = 1'b0;
    logic        Reset;
    logic [3:0]  Request;
    logic [31:0] RequestData;
    logic [3:0]  Grant;
    logic [3:0]  Done;
    logic        AckError;
    logic        Go;
    logic [7:0]  WriteData;
    logic        Busy;
    logic        AckBit;

    int   assertCount = 0;
    int   failCount   = 0;
    bit   engineOn    = 1'b1;
    int   busyCycles  = 20;
    logic engineAck   = 1'b0;
    bit   multiGrant  = 1'b0;

    always #5 clock = ~clock;

    i2c_bus_arbiter dut (
        .clock       (clock),
        .Reset       (Reset),
        .Request     (Request),
        .RequestData (RequestData),
        .Grant       (Grant),
        .Done        (Done),
        .AckError    (AckError),
        .Go          (Go),
        .WriteData   (WriteData),
        .Busy        (Busy),
        .AckBit      (AckBit)
    );

    // Engine model: on Go, raise Busy one cycle later, hold busyCycles, then report engineAck
    initial begin
        Busy   = 1'b0;
        AckBit = 1'b0;
        forever begin
            @(negedge clock);
            if (engineOn && Go) begin
                @(posedge clock);
                #1;
                Busy   = 1'b1;
                AckBit = 1'b0;
                repeat (busyCycles) @(posedge clock);
                #1;
                AckBit = engineAck;
                Busy   = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (!$onehot0(Grant)) multiGrant = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic waitDone(input int limit, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < limit) begin
            @(negedge clock);
            waited++;
            if (|Done) seen = 1'b1;
        end
    endtask

    task automatic waitWaitState(input int limit, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clock);
            if (Grant != 4'b0 && !Go && Busy) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; Request = '0; RequestData = '0;
        repeat (3) @(negedge clock);
        assertCount++; if (Grant !== 4'b0) begin failCount++; $display("FAIL reset_grant: got %b expected 0000", Grant); end
        assertCount++; if (Done !== 4'b0) begin failCount++; $display("FAIL reset_done: got %b expected 0000", Done); end
        assertCount++; if (Go !== 1'b0) begin failCount++; $display("FAIL reset_go: got %b expected 0", Go); end
        assertCount++; if (AckError !== 1'b0) begin failCount++; $display("FAIL reset_ackerror: got %b expected 0", AckError); end
        assertCount++; if (WriteData !== 8'h00) begin failCount++; $display("FAIL reset_writedata: got %h expected 00", WriteData); end
        Reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_round_robin();
        int         order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] expOh;
        logic [7:0] expByte;
        bit         seen;
        int         waited;
        busyCycles  = 3;
        multiGrant  = 1'b0;
        RequestData = 32'h13121110;
        Request     = 4'hF;
        for (int k = 0; k < 5; k++) begin
            expOh   = 4'b0001 << order[k];
            expByte = 8'h10 + 8'(order[k]);
            waitDone(200, seen, waited);
            assertCount++;
            if (!seen) begin
                failCount++; $display("FAIL rr_done_timeout[%0d]: got none expected %b", k, expOh);
            end else begin
                assertCount++; if (Done !== expOh) begin failCount++; $display("FAIL rr_order[%0d]: got %b expected %b", k, Done, expOh); end
                assertCount++; if (WriteData !== expByte) begin failCount++; $display("FAIL rr_data[%0d]: got %h expected %h", k, WriteData, expByte); end
                assertCount++; if (AckError !== 1'b0) begin failCount++; $display("FAIL rr_ackerror[%0d]: got %b expected 0", k, AckError); end
                if (k == 4) Request = 4'h0;
                @(negedge clock);
                assertCount++; if (Done !== 4'b0) begin failCount++; $display("FAIL rr_done_pulse[%0d]: got %b expected 0000", k, Done); end
            end
        end
        assertCount++; if (multiGrant !== 1'b0) begin failCount++; $display("FAIL rr_onehot: got %b expected 0", multiGrant); end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single();
        int  goCycles;
        bit  seen;
        int  waited;
        busyCycles = 20;
        @(posedge clock);
        #1;
        Request     = 4'b0001;
        RequestData = 32'h000000A5;
        @(negedge clock);
        @(negedge clock);
        assertCount++; if (Go !== 1'b0) begin failCount++; $display("FAIL single_go_early: got %b expected 0", Go); end
        @(negedge clock);
        assertCount++; if (Go !== 1'b1) begin failCount++; $display("FAIL single_go_cycle2: got %b expected 1", Go); end
        assertCount++; if (Grant !== 4'b0001) begin failCount++; $display("FAIL single_grant: got %b expected 0001", Grant); end
        assertCount++; if (WriteData !== 8'hA5) begin failCount++; $display("FAIL single_data: got %h expected a5", WriteData); end
        goCycles = 1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (!Go) break;
            goCycles++;
        end
        assertCount++; if (goCycles !== 2) begin failCount++; $display("FAIL single_go_len: got %0d expected 2", goCycles); end
        waitDone(100, seen, waited);
        assertCount++; if (waited !== 20) begin failCount++; $display("FAIL single_done_latency: got %0d expected 20", waited); end
        assertCount++; if (Done !== 4'b0001) begin failCount++; $display("FAIL single_done: got %b expected 0001", Done); end
        assertCount++; if (AckError !== 1'b0) begin failCount++; $display("FAIL single_ackerror: got %b expected 0", AckError); end
        Request = 4'b0;
        @(negedge clock);
        assertCount++; if (Done !== 4'b0) begin failCount++; $display("FAIL single_done_pulse: got %b expected 0000", Done); end
        @(negedge clock);
        assertCount++; if (Grant !== 4'b0) begin failCount++; $display("FAIL single_grant_clear: got %b expected 0000", Grant); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_nack();
        bit seen;
        int waited;
        busyCycles  = 5;
        engineAck   = 1'b1;
        RequestData = 32'h005A0000;
        Request     = 4'b0100;
        waitDone(100, seen, waited);
        assertCount++; if (Done !== 4'b0100) begin failCount++; $display("FAIL nack_done: got %b expected 0100", Done); end
        assertCount++; if (AckError !== 1'b1) begin failCount++; $display("FAIL nack_ackerror: got %b expected 1", AckError); end
        assertCount++; if (WriteData !== 8'h5A) begin failCount++; $display("FAIL nack_data: got %h expected 5a", WriteData); end
        engineAck   = 1'b0;
        RequestData = 32'h005A0077;
        Request     = 4'b0101;
        @(negedge clock);
        waitDone(100, seen, waited);
        assertCount++; if (Done !== 4'b0001) begin failCount++; $display("FAIL nack_ptr_advance: got %b expected 0001", Done); end
        assertCount++; if (WriteData !== 8'h77) begin failCount++; $display("FAIL nack_next_data: got %h expected 77", WriteData); end
        assertCount++; if (AckError !== 1'b0) begin failCount++; $display("FAIL nack_next_ackerror: got %b expected 0", AckError); end
        Request = 4'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_timeout();
        int goCycles;
        bit sawGo;
        engineOn    = 1'b0;
        RequestData = 32'h00008800;
        Request     = 4'b0010;
        sawGo       = 1'b0;
        for (int n = 0; n < 10 && !sawGo; n++) begin
            @(negedge clock);
            if (Go) sawGo = 1'b1;
        end
        assertCount++; if (!sawGo) begin failCount++; $display("FAIL timeout_go_start: got 0 expected 1"); end
        goCycles = 1;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clock);
            if (!Go) break;
            goCycles++;
        end
        assertCount++; if (goCycles !== TMAX + 1) begin failCount++; $display("FAIL timeout_go_len: got %0d expected %0d", goCycles, TMAX + 1); end
        assertCount++; if (Done !== 4'b0010) begin failCount++; $display("FAIL timeout_done: got %b expected 0010", Done); end
        assertCount++; if (AckError !== 1'b1) begin failCount++; $display("FAIL timeout_ackerror: got %b expected 1", AckError); end
        Request = 4'b0;
        @(negedge clock);
        assertCount++; if (Done !== 4'b0) begin failCount++; $display("FAIL timeout_done_pulse: got %b expected 0000", Done); end
        assertCount++; if (Grant !== 4'b0) begin failCount++; $display("FAIL timeout_idle_grant: got %b expected 0000", Grant); end
        assertCount++; if (Go !== 1'b0) begin failCount++; $display("FAIL timeout_idle_go: got %b expected 0", Go); end
        engineOn = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset_midwait();
        bit seen;
        int waited;
        busyCycles  = 20;
        RequestData = 32'hEE000000;
        Request     = 4'b1100;
        waitWaitState(30, seen);
        assertCount++; if (!seen) begin failCount++; $display("FAIL rst_reach_wait: got 0 expected 1"); end
        repeat (3) @(negedge clock);
        Reset = 1'b1;
        #1;
        assertCount++; if (Go !== 1'b0) begin failCount++; $display("FAIL rst_go: got %b expected 0", Go); end
        assertCount++; if (Grant !== 4'b0) begin failCount++; $display("FAIL rst_grant: got %b expected 0000", Grant); end
        assertCount++; if (Done !== 4'b0) begin failCount++; $display("FAIL rst_done: got %b expected 0000", Done); end
        Request     = 4'b1010;
        RequestData = 32'h00004400;
        for (int n = 0; n < 40 && Busy; n++) @(negedge clock);
        @(negedge clock);
        Reset = 1'b0;
        waitDone(100, seen, waited);
        assertCount++; if (Done !== 4'b0010) begin failCount++; $display("FAIL rst_first_grant: got %b expected 0010", Done); end
        assertCount++; if (WriteData !== 8'h44) begin failCount++; $display("FAIL rst_first_data: got %h expected 44", WriteData); end
        Request = 4'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_midwait_change();
        bit seen;
        int waited;
        busyCycles  = 10;
        RequestData = 32'h0000003C;
        Request     = 4'b0001;
        waitWaitState(30, seen);
        assertCount++; if (!seen) begin failCount++; $display("FAIL chg_reach_wait: got 0 expected 1"); end
        Request     = 4'b0;
        RequestData = 32'hFFFFFFC3;
        @(negedge clock);
        assertCount++; if (WriteData !== 8'h3C) begin failCount++; $display("FAIL chg_data_hold: got %h expected 3c", WriteData); end
        waitDone(100, seen, waited);
        assertCount++; if (Done !== 4'b0001) begin failCount++; $display("FAIL chg_done: got %b expected 0001", Done); end
        assertCount++; if (WriteData !== 8'h3C) begin failCount++; $display("FAIL chg_data_done: got %h expected 3c", WriteData); end
        assertCount++; if (AckError !== 1'b0) begin failCount++; $display("FAIL chg_ackerror: got %b expected 0", AckError); end
        repeat (3) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_nack();
        test_timeout();
        test_reset_midwait();
        test_midwait_change();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
